mure_retire_serializer: RTL

Parametrised successor to the two-port retirement serializer. Accepts up to NRET retired instructions per cycle from the commit stage, buffers them as rows in a FIFO, and emits exactly one valid instruction per cycle toward the trace encoder FSM over a valid/ready handshake. Unlike its predecessor, it skips invalid lanes and truncates a row after an exception or interrupt lane. It also detects and counts rows lost to overflow.

---
 rtl/mure_pkg.sv | 47 ++++
 rtl/mure_lane_picker.sv | 33 +++
 rtl/mure_retire_serializer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// ============================================================================
// Module  : mure_pkg
// Purpose : Shared types and widths for the MURE retire serializer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mure_pkg;

    localparam int XLEN       = 32;
    localparam int ITYPE_LEN  = 4;
    localparam int PRIV_LEN   = 2;
    localparam int CAUSE_LEN  = 6;
    // Row storage is sized for the widest supported commit stage; NRET <= NRET_MAX.
    localparam int NRET_MAX   = 8;
    localparam int LANE_IDX_W = $clog2(NRET_MAX);

    typedef enum logic [ITYPE_LEN-1:0] {
        ITYPE_NONE = 4'd0,
        ITYPE_EXC  = 4'd1,
        ITYPE_INT  = 4'd2,
        ITYPE_ERET = 4'd3,
        ITYPE_NTB  = 4'd4,
        ITYPE_TB   = 4'd5
    } itype_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        itype_e          itype;
        logic            compressed;
    } ser_lane_t;

    typedef struct packed {
        logic [NRET_MAX-1:0]      mask;
        ser_lane_t [NRET_MAX-1:0] lanes;
        logic [PRIV_LEN-1:0]      priv;
        logic [CAUSE_LEN-1:0]     cause;
        logic [XLEN-1:0]          tval;
    } ser_row_t;

    function automatic logic is_trap(input itype_e it);
        return (it == ITYPE_EXC) || (it == ITYPE_INT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mure_lane_picker.sv
// ============================================================================
// Module  : mure_lane_picker
// Purpose : Lowest-set-bit finder with found and is-last flags.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mure_lane_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o,
    output logic          last_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    // mask & (mask-1) clears the lowest set bit; nothing left means last.
    assign found_o = |mask_i;
    assign last_o  = found_o && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/mure_retire_serializer.sv
// ============================================================================
// Module  : mure_retire_serializer
// Purpose : Buffers multi-lane retire rows, emits one instruction per cycle.
//           Optional MURE_SER_DROP_CNT_EN adds a saturating drop counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mure_retire_serializer
    import mure_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRET-1:0]           valid_i,
    input  logic [NRET*XLEN-1:0]      pc_i,
    input  logic [NRET*ITYPE_LEN-1:0] itype_i,
    input  logic [NRET-1:0]           compressed_i,
    input  logic [PRIV_LEN-1:0]       priv_i,
    input  logic [CAUSE_LEN-1:0]      cause_i,
    input  logic [XLEN-1:0]           tval_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [XLEN-1:0]           pc_o,
    output logic [ITYPE_LEN-1:0]      itype_o,
    output logic                      compressed_o,
    output logic [PRIV_LEN-1:0]       priv_o,
    output logic [CAUSE_LEN-1:0]      cause_o,
    output logic [XLEN-1:0]           tval_o,
    output logic                      last_o,
    output logic                      full_o,
    output logic                      overflow_o
`ifdef MURE_SER_DROP_CNT_EN
    ,
    output logic [15:0]               drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    ser_row_t            mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         cnt_q;
    logic                overflow_q;
`ifdef MURE_SER_DROP_CNT_EN
    logic [15:0]         drop_cnt_q;
`endif

    ser_row_t            row_d;
    logic                trap_seen;
    logic [LANE_IDX_W-1:0] pick_idx;
    logic                pick_found;
    logic                pick_last;
    ser_lane_t           head_lane;
    logic                xfer;
    logic                push;
    logic                pop;
    logic                push_ok;

    // Lanes after the first valid trap lane are masked off: the row ends there.
    always_comb begin
        row_d     = '0;
        trap_seen = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            row_d.lanes[i].pc         = pc_i[i*XLEN +: XLEN];
            row_d.lanes[i].itype      = itype_e'(itype_i[i*ITYPE_LEN +: ITYPE_LEN]);
            row_d.lanes[i].compressed = compressed_i[i];
            if (valid_i[i] && !trap_seen) begin
                row_d.mask[i] = 1'b1;
                if (is_trap(row_d.lanes[i].itype)) begin
                    trap_seen = 1'b1;
                end
            end
        end
        row_d.priv  = priv_i;
        row_d.cause = cause_i;
        row_d.tval  = tval_i;
    end

    mure_lane_picker #(
        .N  (NRET_MAX),
        .IW (LANE_IDX_W)
    ) u_picker (
        .mask_i  (mem_q[rd_ptr_q].mask),
        .idx_o   (pick_idx),
        .found_o (pick_found),
        .last_o  (pick_last)
    );

    assign head_lane = mem_q[rd_ptr_q].lanes[pick_idx];

    assign valid_o      = (cnt_q != '0) && pick_found;
    assign last_o       = valid_o && pick_last;
    assign pc_o         = valid_o ? head_lane.pc : '0;
    assign itype_o      = valid_o ? head_lane.itype : '0;
    assign compressed_o = valid_o && head_lane.compressed;
    assign priv_o       = valid_o ? mem_q[rd_ptr_q].priv : '0;
    assign cause_o      = valid_o ? mem_q[rd_ptr_q].cause : '0;
    assign tval_o       = valid_o ? mem_q[rd_ptr_q].tval : '0;
    assign full_o       = (cnt_q == (AW+1)'(DEPTH));
    assign overflow_o   = overflow_q;
`ifdef MURE_SER_DROP_CNT_EN
    assign drop_cnt_o   = drop_cnt_q;
`endif

    assign xfer    = valid_o && ready_i;
    assign pop     = xfer && pick_last;
    assign push    = |valid_i;
    assign push_ok = push && (!full_o || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef MURE_SER_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (xfer) begin
                mem_q[rd_ptr_q].mask[pick_idx] <= 1'b0;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Written after the mask clear so a full-FIFO push/pop to the same slot lands the new row.
            if (push_ok) begin
                mem_q[wr_ptr_q] <= row_d;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end else if (push) begin
                overflow_q <= 1'b1;
`ifdef MURE_SER_DROP_CNT_EN
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
`endif
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire
